// File: rtl/exc_pkg.sv
// exc_pkg -- shared definitions for the MEM-stage exception collector.
//   EXC_*     : bit positions inside the 32-bit cp0 exception_type word
//   MEM_OP_*  : data-memory operation codes carried from EX
//   stage_state_e : stage FSM (RUN accepts work, DRAIN discards after a flush)
//   align_res_t   : result bundle of the alignment / byte-lane checker
package exc_pkg;

  localparam int EXC_ADEL_IF = 31;  // fetch address error
  localparam int EXC_RI      = 30;  // reserved instruction
  localparam int EXC_OV      = 29;  // arithmetic overflow
  localparam int EXC_BP      = 28;  // breakpoint
  localparam int EXC_SYS     = 27;  // syscall
  localparam int EXC_ADEL_LD = 26;  // misaligned load
  localparam int EXC_ADES_ST = 25;  // misaligned store
  localparam int EXC_ERET    = 0;   // eret

  localparam logic [3:0] MEM_OP_NONE = 4'd0;
  localparam logic [3:0] MEM_OP_LB   = 4'd1;
  localparam logic [3:0] MEM_OP_LBU  = 4'd2;
  localparam logic [3:0] MEM_OP_LH   = 4'd3;
  localparam logic [3:0] MEM_OP_LHU  = 4'd4;
  localparam logic [3:0] MEM_OP_LW   = 4'd5;
  localparam logic [3:0] MEM_OP_SB   = 4'd6;
  localparam logic [3:0] MEM_OP_SH   = 4'd7;
  localparam logic [3:0] MEM_OP_SW   = 4'd8;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic        ld_fault;
    logic        st_fault;
    logic [3:0]  wen;
    logic [31:0] lane_data;
  } align_res_t;

endpackage

// File: rtl/mem_align_chk.sv
// mem_align_chk -- combinational alignment check and store lane formatting.
//   mem_op  : operation code (MEM_OP_*)
//   addr_lo : effective address bits [1:0]
//   wdata   : right-justified store data
//   res     : load/store fault flags, byte write enables, lane-replicated data
// Byte ops never fault; halfword ops fault on an odd address, word ops on any
// nonzero low bits. Loads produce no write enables and no lane data.
module mem_align_chk
  import exc_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output align_res_t  res
);

  always_comb begin
    res = '0;
    case (mem_op)
      MEM_OP_LH, MEM_OP_LHU: res.ld_fault = addr_lo[0];
      MEM_OP_LW:             res.ld_fault = |addr_lo;
      MEM_OP_SB: begin
        res.wen       = 4'b0001 << addr_lo;
        res.lane_data = {4{wdata[7:0]}};
      end
      MEM_OP_SH: begin
        res.st_fault  = addr_lo[0];
        res.wen       = 4'b0011 << addr_lo;
        res.lane_data = {2{wdata[15:0]}};
      end
      MEM_OP_SW: begin
        res.st_fault  = |addr_lo;
        res.wen       = 4'b1111;
        res.lane_data = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exc_mem_stage.sv
// exc_mem_stage -- MEM-stage exception collector between EX and cp0.
// Registers one instruction per cycle, merges upstream exception bits with
// data-address alignment faults, and issues the data-memory request.
//   clk, rst (sync, active-low)
//   stall_i / flush_i        : hold stage / kill stage and drain FLUSH_DRAIN cycles
//   in_valid_i, pc_i, exc_i, is_branch_i, mem_op_i, mem_addr_i, mem_wdata_i : from EX
//   valid_o, exc_type_o, pc_o, exc_addr_o, in_ds_o : to cp0
//   dmem_en_o, dmem_wen_o, dmem_addr_o, dmem_wdata_o : data memory request
// Optional feature macro EXC_LAST_PC_EN: on a bubble, pc_o shows the last
// captured PC+4 and in_ds_o shows ds_flag, giving cp0 a resumable EPC for an
// asynchronous interrupt. Without it pc_o and in_ds_o are 0 on a bubble.
module exc_mem_stage
  import exc_pkg::*;
#(
  parameter int FLUSH_DRAIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] exc_i,
  input  logic        is_branch_i,
  input  logic [3:0]  mem_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        valid_o,
  output logic [31:0] exc_type_o,
  output logic [31:0] pc_o,
  output logic [31:0] exc_addr_o,
  output logic        in_ds_o,
  output logic        dmem_en_o,
  output logic [3:0]  dmem_wen_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o
);

  localparam int CW = (FLUSH_DRAIN < 2) ? 1 : $clog2(FLUSH_DRAIN + 1);

  align_res_t   aln;
  logic [31:0]  exc_next;
  logic         fault_ok;
  logic         addr_fault;

  stage_state_e state;
  logic [CW-1:0] drain_cnt;
  logic         valid;
  logic         issued;     // instruction already shown to cp0/memory once
  logic         ds_flag;    // previous captured instruction owns a delay slot
  logic [31:0]  pc_r;
  logic [31:0]  exc_r;
  logic [31:0]  exc_addr_r;
  logic         in_ds_r;
  logic         req_ok_r;   // memory op present and no exception at all
  logic [3:0]   wen_r;
  logic [31:0]  waddr_r;
  logic [31:0]  wdata_r;
  logic         first;
`ifdef EXC_LAST_PC_EN
  logic [31:0]  next_pc_r;
`endif

  mem_align_chk u_align (
    .mem_op  (mem_op_i),
    .addr_lo (mem_addr_i[1:0]),
    .wdata   (mem_wdata_i),
    .res     (aln)
  );

  // Alignment faults only matter when no earlier-stage exception is pending.
  always_comb begin
    fault_ok              = ~|exc_i[EXC_ADEL_IF:EXC_SYS];
    exc_next              = exc_i;
    exc_next[EXC_ADEL_LD] = exc_i[EXC_ADEL_LD] | (fault_ok & aln.ld_fault);
    exc_next[EXC_ADES_ST] = exc_i[EXC_ADES_ST] | (fault_ok & aln.st_fault);
    addr_fault            = fault_ok & (aln.ld_fault | aln.st_fault);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      valid      <= 1'b0;
      issued     <= 1'b0;
      ds_flag    <= 1'b0;
      pc_r       <= '0;
      exc_r      <= '0;
      exc_addr_r <= '0;
      in_ds_r    <= 1'b0;
      req_ok_r   <= 1'b0;
      wen_r      <= '0;
      waddr_r    <= '0;
      wdata_r    <= '0;
`ifdef EXC_LAST_PC_EN
      next_pc_r  <= '0;
`endif
    end else if (flush_i) begin
      state     <= ST_DRAIN;
      drain_cnt <= CW'(FLUSH_DRAIN);
      valid     <= 1'b0;
      ds_flag   <= 1'b0;
    end else if (stall_i) begin
      // Everything holds; only remember that the content was already issued.
      issued <= valid;
    end else if (state == ST_DRAIN) begin
      valid     <= 1'b0;
      drain_cnt <= drain_cnt - CW'(1);
      if (drain_cnt == CW'(1)) state <= ST_RUN;
    end else begin
      valid  <= in_valid_i;
      issued <= 1'b0;
      if (in_valid_i) begin
        pc_r       <= pc_i;
        exc_r      <= exc_next;
        exc_addr_r <= addr_fault ? mem_addr_i : pc_i;
        in_ds_r    <= ds_flag;
        ds_flag    <= is_branch_i;
        req_ok_r   <= (mem_op_i != MEM_OP_NONE) && (exc_next == '0);
        wen_r      <= aln.wen;
        waddr_r    <= {mem_addr_i[31:2], 2'b00};
        wdata_r    <= aln.lane_data;
`ifdef EXC_LAST_PC_EN
        next_pc_r  <= pc_i + 32'd4;
`endif
      end
    end
  end

  // The request side is all-zero unless the strobe fires, so memory never
  // sees stale lanes from a faulting or already-issued instruction.
  always_comb begin
    first        = valid & ~issued;
    valid_o      = valid;
    exc_type_o   = first ? exc_r : '0;
    exc_addr_o   = valid ? exc_addr_r : '0;
    dmem_en_o    = first & req_ok_r;
    dmem_wen_o   = dmem_en_o ? wen_r   : '0;
    dmem_addr_o  = dmem_en_o ? waddr_r : '0;
    dmem_wdata_o = dmem_en_o ? wdata_r : '0;
`ifdef EXC_LAST_PC_EN
    pc_o         = valid ? pc_r : next_pc_r;
    in_ds_o      = valid ? in_ds_r : ds_flag;
`else
    pc_o         = valid ? pc_r : '0;
    in_ds_o      = valid & in_ds_r;
`endif
  end

endmodule

// File: tb/tb_exc_mem_stage.sv
// Bench for exc_mem_stage (default build, FLUSH_DRAIN=2): directed cases with
// literal expectations, then randomized traffic checked every cycle against
// an instruction-level reference model.
module tb_exc_mem_stage;
  localparam int FD = 2;

  logic clk = 1'b0;
  logic rst, stall_i, flush_i, in_valid_i, is_branch_i;
  logic [31:0] pc_i, exc_i, mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic        valid_o, in_ds_o, dmem_en_o;
  logic [31:0] exc_type_o, pc_o, exc_addr_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wen_o;

  always #5 clk = ~clk;

  exc_mem_stage #(.FLUSH_DRAIN(FD)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .pc_i(pc_i), .exc_i(exc_i), .is_branch_i(is_branch_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .valid_o(valid_o), .exc_type_o(exc_type_o), .pc_o(pc_o), .exc_addr_o(exc_addr_o),
    .in_ds_o(in_ds_o), .dmem_en_o(dmem_en_o), .dmem_wen_o(dmem_wen_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o)
  );

  // Reference model: the instruction in the stage and a few flags.
  typedef struct {
    bit [31:0] pc, exc, addr, wdata;
    int        op;
    bit        ds;
  } instr_t;

  instr_t cur;
  bit m_valid = 0, m_issued = 0, m_ds = 0;
  int m_drain = 0;
  int vectors = 0, miscompares = 0;
  bit cmp_en = 0;

  function automatic bit [31:0] exc_of(bit [31:0] e, int op, bit [31:0] a);
    bit [31:0] r;
    r = e;
    if (e[31:27] == 5'd0) begin
      if ((op == 3 || op == 4) && a % 2 != 0) r[26] = 1'b1;
      if (op == 5 && a % 4 != 0)              r[26] = 1'b1;
      if (op == 7 && a % 2 != 0)              r[25] = 1'b1;
      if (op == 8 && a % 4 != 0)              r[25] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_valid = 0; m_issued = 0; m_ds = 0; m_drain = 0;
    end else if (flush_i) begin
      m_valid = 0; m_ds = 0; m_drain = FD;
    end else if (stall_i) begin
      if (m_valid) m_issued = 1;
    end else if (m_drain > 0) begin
      m_drain--; m_valid = 0;
    end else begin
      m_valid  = in_valid_i;
      m_issued = 0;
      if (in_valid_i) begin
        cur.pc    = pc_i;
        cur.op    = int'(mem_op_i);
        cur.addr  = mem_addr_i;
        cur.wdata = mem_wdata_i;
        cur.exc   = exc_of(exc_i, cur.op, mem_addr_i);
        cur.ds    = m_ds;
        m_ds      = is_branch_i;
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    chk(name, act, exp);
  endtask

  // Per-cycle comparison against the model.
  bit        e_first, e_en, e_fault;
  bit [31:0] e_wen, e_wdata;
  always @(negedge clk) if (cmp_en) begin
    e_first = m_valid && !m_issued;
    e_fault = cur.exc[26] | cur.exc[25];
    e_en    = e_first && cur.op != 0 && cur.exc == 0;
    e_wen   = 0;
    e_wdata = 0;
    if (e_en) begin
      case (cur.op)
        6: begin e_wen = (1 << (cur.addr % 4)) & 15; e_wdata = (cur.wdata & 32'hFF) * 32'h0101_0101; end
        7: begin e_wen = (3 << (cur.addr % 4)) & 15; e_wdata = (cur.wdata & 32'hFFFF) * 32'h0001_0001; end
        8: begin e_wen = 15; e_wdata = cur.wdata; end
        default: ;
      endcase
    end
    vectors++;
    chk("valid",    32'(valid_o),    32'(m_valid));
    chk("exc_type", exc_type_o,      e_first ? cur.exc : 0);
    chk("pc",       pc_o,            m_valid ? cur.pc : 0);
    chk("exc_addr", exc_addr_o,      m_valid ? (e_fault ? cur.addr : cur.pc) : 0);
    chk("in_ds",    32'(in_ds_o),    32'(m_valid && cur.ds));
    chk("dmem_en",  32'(dmem_en_o),  32'(e_en));
    chk("dmem_wen", 32'(dmem_wen_o), e_wen);
    chk("dmem_addr", dmem_addr_o,    e_en ? cur.addr - cur.addr % 4 : 0);
    chk("dmem_wdata", dmem_wdata_o,  e_wdata);
  end

  task automatic set_in(bit v, int op, bit [31:0] pc, bit [31:0] a, bit [31:0] wd,
                        bit [31:0] e, bit br);
    in_valid_i = v; mem_op_i = 4'(op); pc_i = pc; mem_addr_i = a;
    mem_wdata_i = wd; exc_i = e; is_branch_i = br;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 0; stall_i = 0; flush_i = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    cmp_en = 1;
    lit("rst_valid", 32'(valid_o), 0);
    lit("rst_exc",   exc_type_o,   0);
    lit("rst_en",    32'(dmem_en_o), 0);
    rst = 1;

    // aligned SW
    set_in(1, 8, 32'h80, 32'h100, 32'h1234_5678, 0, 0); step();
    lit("sw_en",    32'(dmem_en_o),  1);
    lit("sw_wen",   32'(dmem_wen_o), 32'hF);
    lit("sw_addr",  dmem_addr_o,     32'h100);
    lit("sw_exc",   exc_type_o,      0);
    lit("sw_wdata", dmem_wdata_o,    32'h1234_5678);

    // misaligned LW
    set_in(1, 5, 32'hBFC0_0010, 32'h102, 0, 0, 0); step();
    lit("lw_exc",  exc_type_o, 32'h0400_0000);
    lit("lw_addr", exc_addr_o, 32'h102);
    lit("lw_en",   32'(dmem_en_o), 0);

    // misaligned SH masked by upstream RI
    set_in(1, 7, 32'h300, 32'h201, 0, 32'h4000_0000, 0); step();
    lit("sh_exc",  exc_type_o, 32'h4000_0000);
    lit("sh_addr", exc_addr_o, 32'h300);
    lit("sh_en",   32'(dmem_en_o), 0);

    // branch then SB in delay slot
    set_in(1, 0, 32'h40, 0, 0, 0, 1); step();
    set_in(1, 6, 32'h44, 32'h3, 32'hAB, 0, 0); step();
    lit("ds_flag",  32'(in_ds_o),    1);
    lit("sb_wen",   32'(dmem_wen_o), 32'h8);
    lit("sb_wdata", dmem_wdata_o,    32'hABAB_ABAB);

    // SW issued once, then held by a stall
    set_in(1, 8, 32'h500, 32'h600, 32'hCAFE_F00D, 0, 0); step();
    lit("st_en0", 32'(dmem_en_o), 1);
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      lit("st_en_hold", 32'(dmem_en_o), 0);
      lit("st_valid",   32'(valid_o),   1);
    end
    stall_i = 0;

    // flush kills the stage, drains 2 cycles, clears ds_flag
    set_in(1, 0, 32'h700, 0, 0, 0, 1); step();
    set_in(1, 8, 32'h704, 32'h800, 32'h1, 0, 0);
    flush_i = 1; step();
    lit("fl_valid0", 32'(valid_o), 0);
    flush_i = 0; step();
    lit("fl_valid1", 32'(valid_o), 0);
    step();
    lit("fl_valid2", 32'(valid_o), 0);
    step();
    lit("fl_resume", 32'(valid_o), 1);
    lit("fl_ds",     32'(in_ds_o), 0);
    lit("fl_pc",     pc_o,         32'h704);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(99) != 0);
      flush_i = ($urandom_range(15) == 0);
      stall_i = ($urandom_range(4) == 0);
      set_in($urandom_range(3) != 0, $urandom_range(8), $urandom & 32'hFFFF_FFFC,
             $urandom, $urandom,
             ($urandom_range(3) == 0) ? ($urandom & 32'hF800_0001) : 32'h0,
             $urandom_range(3) == 0);
      step();
    end

    rst = 1; flush_i = 0; stall_i = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step(); step();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
